branch_predictor: RTL and testbench
===================================

# branch_predictor

Branch history table for the Issue/IFetch front end. Holds 2^IDX_W two-bit saturating counters indexed by PC: it answers one prediction query per cycle from instruction fetch, one cycle later, and absorbs one resolved-branch update per cycle from commit. It also keeps branch and misprediction statistics.

## Interface
Parameters:
- IDX_W, 8, index width; the table holds 2^IDX_W entries.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; when low, the block holds all state.
- query_valid  input  1  fetch requests a prediction.
- query_pc  input  32  PC of the fetched branch.
- resp_valid  output  1  prediction valid (registered).
- resp_taken  output  1  predicted direction: 1 = taken, 0 = not taken.
- resp_pc  output  32  echo of the queried PC.
- upd_valid  input  1  commit reports a resolved conditional branch.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  actual outcome.
- upd_pred  input  1  direction that was predicted for this branch.
- stat_branches  output  CNT_W  count of committed branches.
- stat_misses  output  CNT_W  count of commits where upd_pred != upd_taken.

## Operation
- Index = pc[IDX_W+1:2]. Instructions are 4-byte aligned; pc[1:0] is ignored.
- Counter encoding: 00 strongly not taken, 01 weakly not taken, 10 weakly taken, 11 strongly taken. Prediction = counter bit 1.
- Update rule for table[upd index]:
  - upd_taken = 1: increment, saturating at 11.
  - upd_taken = 0: decrement, saturating at 00.
  - No wrap-around is allowed in either direction.
- Query: when query_valid is high, the prediction for table[query index] is registered into resp_taken and resp_pc.
- Same-cycle collision: if upd_valid and query_valid are both high and the indices match, the response uses the post-update counter value (write-first bypass).
- Aliasing: different PCs with the same index share one counter. No tags are kept.
- Statistics: each accepted update increments stat_branches by 1. stat_misses increments by 1 when upd_pred != upd_taken. Both counters wrap modulo 2^CNT_W.
- rdy_in low:
  - No table write, no statistics change.
  - resp_valid, resp_taken and resp_pc hold their values.
  - query_valid and upd_valid are ignored, not queued.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - every table entry = 01;
  - resp_valid = 0, resp_taken = 0, resp_pc = 0;
  - stat_branches = 0, stat_misses = 0.
- Query latency is 1 cycle. A query sampled at edge N with rdy_in = 1 produces resp_valid = 1 after edge N, for exactly one cycle unless another query follows.
- Throughput: one query and one update per cycle, with no back-pressure.
- An update sampled at edge N is visible to a query sampled at edge N (through the bypass) and to every later query.
- Reset asserted mid-stream: the in-flight response is dropped (resp_valid = 0) and the table reinitialises immediately.

## Structure
- Shared package: counter state constants (SNT, WNT, WT, ST), the reset value WNT, the index-extraction function, and the sat2_next(state, taken) next-state function.
- The table is a flop array inline in branch_predictor, because async reset of every entry rules out SRAM inference.
- No sub-module is required; the saturating logic is the package function.

## Test plan
- Reset then query PC 0x1000 → resp_valid = 1 one cycle later, resp_taken = 0, resp_pc = 0x1000.
- Three updates for PC 0x1000 with taken = 1, then a query → counter 01→10→11→11, resp_taken = 1; a further taken update does not wrap to 00.
- From 11, two not-taken updates then a query → counter reaches 01, resp_taken = 0; two more decrements hold at 00.
- Same cycle, update PC 0x2004 (taken) and query PC 0x2004 from reset state → resp_taken = 1 (bypass). Aliasing check: PC 0x2004 + (4 << IDX_W) then predicts the same value.
- Five updates with upd_pred/upd_taken pairs (1,1), (0,1), (1,0), (0,0), (1,1) → stat_branches = 5, stat_misses = 2.
- Hold rdy_in = 0 for 3 cycles while driving a query and an update:
  - no table change, stats unchanged, responses held;
  - assert rst_in low mid-sequence → all outputs 0 and table entries 01 without waiting for a clock edge.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch history table.
// Holds the 2-bit counter state encodings, the counter reset value, the
// PC-to-index helper and the saturating next-state function.
package branch_predictor_pkg;

  // 2-bit counter encodings; bit 1 is the predicted direction.
  localparam logic [1:0] SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] WT  = 2'b10;  // weakly taken
  localparam logic [1:0] ST  = 2'b11;  // strongly taken

  localparam logic [1:0] CNT_RESET = WNT;

  // Word address of an instruction; callers keep the low IDX_W bits as the index.
  function automatic logic [29:0] pc_word(input logic [31:0] pc);
    return pc[31:2];
  endfunction

  // Saturating up/down step; never wraps in either direction.
  function automatic logic [1:0] sat2_next(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    nxt = state;
    if (taken) begin
      if (state != ST) nxt = state + 2'd1;
    end else begin
      if (state != SNT) nxt = state - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Branch history table: 2^IDX_W two-bit saturating counters indexed by PC.
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global stall when low)
//   query_valid/query_pc      -> resp_valid/resp_taken/resp_pc one cycle later
//   upd_valid/upd_pc/upd_taken/upd_pred  resolved-branch update from commit
//   stat_branches/stat_misses  wrapping statistics counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             query_valid,
  input  logic [31:0]      query_pc,
  output logic             resp_valid,
  output logic             resp_taken,
  output logic [31:0]      resp_pc,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_misses
);

  localparam int unsigned Entries = 2 ** IDX_W;

  logic [1:0]       table_q [Entries];
  logic [1:0]       table_d [Entries];
  logic             resp_valid_q, resp_valid_d;
  logic             resp_taken_q, resp_taken_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] branches_q, branches_d;
  logic [CNT_W-1:0] misses_q, misses_d;

  logic [29:0]      q_word, u_word;
  logic [IDX_W-1:0] q_idx, u_idx;
  logic             do_upd;

  assign q_word = pc_word(query_pc);
  assign u_word = pc_word(upd_pc);
  assign q_idx  = q_word[IDX_W-1:0];
  assign u_idx  = u_word[IDX_W-1:0];
  assign do_upd = rdy_in && upd_valid;

  always_comb begin
    table_d    = table_q;
    branches_d = branches_q;
    misses_d   = misses_q;
    if (do_upd) begin
      table_d[u_idx] = sat2_next(table_q[u_idx], upd_taken);
      branches_d     = branches_q + CNT_W'(1);
      if (upd_pred != upd_taken) misses_d = misses_q + CNT_W'(1);
    end
  end

  // Reading table_d gives the write-first bypass on an index collision.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_taken_d = resp_taken_q;
    resp_pc_d    = resp_pc_q;
    if (rdy_in) begin
      resp_valid_d = query_valid;
      if (query_valid) begin
        resp_taken_d = table_d[q_idx][1];
        resp_pc_d    = query_pc;
      end
    end
  end

  // Flop array rather than SRAM: every entry needs the async reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < Entries; i++) table_q[i] <= CNT_RESET;
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
      resp_pc_q    <= '0;
      branches_q   <= '0;
      misses_q     <= '0;
    end else begin
      table_q      <= table_d;
      resp_valid_q <= resp_valid_d;
      resp_taken_q <= resp_taken_d;
      resp_pc_q    <= resp_pc_d;
      branches_q   <= branches_d;
      misses_q     <= misses_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_taken    = resp_taken_q;
  assign resp_pc       = resp_pc_q;
  assign stat_branches = branches_q;
  assign stat_misses   = misses_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: reference counter table plus a
// scoreboard queue of expected responses.
module tb_branch_predictor;

  localparam int unsigned IDX_W = 8;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned N     = 2 ** IDX_W;

  typedef struct packed {
    logic        taken;
    logic [31:0] pc;
  } resp_t;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic             rdy_in = 1'b0;
  logic             query_valid = 1'b0;
  logic [31:0]      query_pc = '0;
  logic             resp_valid;
  logic             resp_taken;
  logic [31:0]      resp_pc;
  logic             upd_valid = 1'b0;
  logic [31:0]      upd_pc = '0;
  logic             upd_taken = 1'b0;
  logic             upd_pred = 1'b0;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_misses;

  branch_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .query_valid   (query_valid),
    .query_pc      (query_pc),
    .resp_valid    (resp_valid),
    .resp_taken    (resp_taken),
    .resp_pc       (resp_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_pred      (upd_pred),
    .stat_branches (stat_branches),
    .stat_misses   (stat_misses)
  );

  always #5 clk_in = ~clk_in;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          model [N];
  int unsigned m_br, m_miss;
  resp_t       sb_q [$];
  resp_t       last_resp;
  logic        last_valid;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = 1;
    m_br = 0;
    m_miss = 0;
    sb_q.delete();
    last_resp  = '0;
    last_valid = 1'b0;
  endtask

  // Drive one cycle of stimulus, update the model, then check after the edge.
  task automatic cycle(input logic rdy, input logic qv, input logic [31:0] qpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic up);
    resp_t r;
    rdy_in = rdy; query_valid = qv; query_pc = qpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_pred = up;
    if (rdy && uv) begin
      int k;
      k = idx_of(upc);
      if (ut) begin
        if (model[k] < 3) model[k]++;
      end else begin
        if (model[k] > 0) model[k]--;
      end
      m_br++;
      if (ut != up) m_miss++;
    end
    if (rdy && qv) begin
      r.taken = (model[idx_of(qpc)] >= 2);
      r.pc    = qpc;
      sb_q.push_back(r);
    end
    @(posedge clk_in);
    #1;
    if (rdy) begin
      if (sb_q.size() > 0) begin
        r = sb_q.pop_front();
        check_eq("resp_valid", 64'(resp_valid), 64'd1);
        check_eq("resp_taken", 64'(resp_taken), 64'(r.taken));
        check_eq("resp_pc", 64'(resp_pc), 64'(r.pc));
        last_resp  = r;
        last_valid = 1'b1;
      end else begin
        check_eq("resp_idle", 64'(resp_valid), 64'd0);
        last_valid = 1'b0;
      end
    end else begin
      check_eq("hold_valid", 64'(resp_valid), 64'(last_valid));
      check_eq("hold_taken", 64'(resp_taken), 64'(last_resp.taken));
      check_eq("hold_pc", 64'(resp_pc), 64'(last_resp.pc));
    end
    check_eq("stat_branches", 64'(stat_branches), 64'(m_br));
    check_eq("stat_misses", 64'(stat_misses), 64'(m_miss));
    rdy_in = 1'b1; query_valid = 1'b0; upd_valid = 1'b0;
  endtask

  task automatic query(input logic [31:0] pc);
    cycle(1'b1, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic update(input logic [31:0] pc, input logic t, input logic p);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, pc, t, p);
  endtask

  initial begin
    model_reset();
    #12;
    check_eq("rst_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_pc", 64'(resp_pc), 64'd0);
    check_eq("rst_br", 64'(stat_branches), 64'd0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rdy_in = 1'b1;

    // Reset prediction
    query(32'h1000);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Saturate upward, then one more taken must not wrap
    repeat (3) update(32'h1000, 1'b1, 1'b0);
    query(32'h1000);
    check_eq("cnt_sat_hi", 64'(dut.table_q[idx_of(32'h1000)]), 64'd3);
    update(32'h1000, 1'b1, 1'b1);
    check_eq("cnt_no_wrap_hi", 64'(dut.table_q[idx_of(32'h1000)]), 64'd3);

    // Decrement to 01, then saturate at 00
    repeat (2) update(32'h1000, 1'b0, 1'b1);
    query(32'h1000);
    repeat (2) update(32'h1000, 1'b0, 1'b0);
    check_eq("cnt_sat_lo", 64'(dut.table_q[idx_of(32'h1000)]), 64'd0);
    update(32'h1000, 1'b0, 1'b0);
    query(32'h1000);
    check_eq("cnt_no_wrap_lo", 64'(dut.table_q[idx_of(32'h1000)]), 64'd0);

    // Write-first bypass and aliasing
    cycle(1'b1, 1'b1, 32'h2004, 1'b1, 32'h2004, 1'b1, 1'b0);
    query(32'h2004 + (32'd4 << IDX_W));

    // Statistics pairs (pred, taken)
    update(32'h3000, 1'b1, 1'b1);
    update(32'h3000, 1'b1, 1'b0);
    update(32'h3000, 1'b0, 1'b1);
    update(32'h3000, 1'b0, 1'b0);
    update(32'h3000, 1'b1, 1'b1);

    // Back-to-back queries with concurrent updates
    for (int i = 0; i < 60; i++) begin
      logic [31:0] qa, ua;
      qa = {22'h0, $urandom_range(0, 7), 2'b00} + 32'h4000;
      ua = {22'h0, $urandom_range(0, 7), 2'b00} + 32'h4000;
      cycle(1'b1, 1'($urandom_range(0, 3) != 0), qa, 1'($urandom_range(0, 1)), ua,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Stall: queries and updates ignored, state held
    query(32'h1000);
    repeat (3) cycle(1'b0, 1'b1, 32'h2004, 1'b1, 32'h2004, 1'b0, 1'b1);
    check_eq("stall_tbl", 64'(dut.table_q[idx_of(32'h2004)]), 64'(model[idx_of(32'h2004)]));
    query(32'h2004);
    cycle(1'b0, 1'b1, 32'h1000, 1'b1, 32'h1000, 1'b1, 1'b0);

    // Asynchronous reset mid-sequence
    rdy_in = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    check_eq("arst_valid", 64'(resp_valid), 64'd0);
    check_eq("arst_taken", 64'(resp_taken), 64'd0);
    check_eq("arst_pc", 64'(resp_pc), 64'd0);
    check_eq("arst_br", 64'(stat_branches), 64'd0);
    check_eq("arst_miss", 64'(stat_misses), 64'd0);
    check_eq("arst_tbl_a", 64'(dut.table_q[idx_of(32'h1000)]), 64'd1);
    check_eq("arst_tbl_b", 64'(dut.table_q[idx_of(32'h2004)]), 64'd1);
    check_eq("arst_tbl_c", 64'(dut.table_q[idx_of(32'h4000)]), 64'd1);
    model_reset();
    #1;
    rst_in = 1'b1;
    query(32'h2004);
    query(32'h1000);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
